// File: rtl/aes_state_demux.sv
// aes_state_demux: output-side steering for the AES-128 round datapath.
// Each accepted round result goes back to the feedback register for rounds
// 1..NROUNDS-1. The result of the final round goes to a ciphertext register
// that is held until the consumer completes the out_valid/out_ready handshake.
module aes_state_demux #(
    parameter int WIDTH   = 128,
    parameter int NROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] in_data,
    output logic             fb_valid,
    output logic [0:WIDTH-1] fb_data,
    output logic             out_valid,
    output logic [0:WIDTH-1] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [3:0]       round,
    output logic             drop_err
);

    // The round counter is 4 bits wide, so a block can have at most 15 rounds.
    if (NROUNDS < 2 || NROUNDS > 15) begin : g_bad_nrounds
        $error("aes_state_demux: NROUNDS must be in 2..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // This is the round count just before the final round. A result arriving
    // at this count is the ciphertext.
    localparam logic [3:0] LAST_FB_ROUND = 4'(NROUNDS - 1);
    localparam logic [3:0] FINAL_ROUND   = 4'(NROUNDS);

    state_t             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic               fb_valid_q, fb_valid_d;
    logic [0:WIDTH-1]   fb_data_q, fb_data_d;
    logic               out_valid_q, out_valid_d;
    logic [0:WIDTH-1]   out_data_q, out_data_d;
    logic               drop_err_q, drop_err_d;

    // Next-state, steering and pulse generation.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        fb_valid_d  = 1'b0;
        fb_data_d   = fb_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        drop_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // No block is running, so any round result is discarded.
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                if (start) begin
                    state_d = ST_ROUND;
                    round_d = 4'd0;
                end
            end

            ST_ROUND: begin
                // start is ignored here. A block is never restarted mid-flight.
                if (in_valid) begin
                    if (round_q < LAST_FB_ROUND) begin
                        fb_data_d  = in_data;
                        fb_valid_d = 1'b1;
                        round_d    = round_q + 4'd1;
                    end else begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        round_d     = FINAL_ROUND;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // The ciphertext is being held, so any new round result is discarded.
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                // When start arrives with the accepting edge, the next block
                // begins with no idle cycle between the two blocks.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    round_d     = 4'd0;
                    state_d     = start ? ST_ROUND : ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                round_d     = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter, and data registers. Reset aborts a block at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= 4'd0;
            fb_valid_q  <= 1'b0;
            fb_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            fb_valid_q  <= fb_valid_d;
            fb_data_q   <= fb_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign fb_valid  = fb_valid_q;
    assign fb_data   = fb_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign drop_err  = drop_err_q;
    assign round     = round_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_state_demux.sv
// Testbench for aes_state_demux. It drives two instances, one with
// NROUNDS=10 and one with NROUNDS=2, from shared inputs. A behavioural
// model of each instance predicts all outputs on every cycle. Literal
// expectations pin the directed scenarios.
module tb_aes_state_demux;
    localparam int W = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, out_ready;
    logic [0:W-1]  in_data;

    logic          fbv_a, ov_a, busy_a, drop_a;
    logic [0:W-1]  fbd_a, od_a;
    logic [3:0]    rnd_a;
    logic          fbv_b, ov_b, busy_b, drop_b;
    logic [0:W-1]  fbd_b, od_b;
    logic [3:0]    rnd_b;

    aes_state_demux #(.WIDTH(W), .NROUNDS(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .fb_valid(fbv_a), .fb_data(fbd_a), .out_valid(ov_a), .out_data(od_a),
        .out_ready(out_ready), .busy(busy_a), .round(rnd_a), .drop_err(drop_a)
    );

    aes_state_demux #(.WIDTH(W), .NROUNDS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .fb_valid(fbv_b), .fb_data(fbd_b), .out_valid(ov_b), .out_data(od_b),
        .out_ready(out_ready), .busy(busy_b), .round(rnd_b), .drop_err(drop_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model. Phase: 0 = no block, 1 = collecting rounds,
    // 2 = ciphertext waiting for the consumer. m_cnt = rounds completed.
    int           m_ph [2];
    int           m_cnt[2];
    logic         m_fbv[2], m_ov[2], m_drop[2];
    logic [W-1:0] m_fbd[2], m_od[2];

    function automatic int nr_of(input int i);
        return (i == 0) ? 10 : 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ph[i] = 0; m_cnt[i] = 0;
                m_fbv[i] = 1'b0; m_ov[i] = 1'b0; m_drop[i] = 1'b0;
                m_fbd[i] = '0;   m_od[i] = '0;
            end else begin
                m_fbv[i]  = 1'b0;
                m_drop[i] = 1'b0;
                if (m_ph[i] == 0) begin
                    if (in_valid) m_drop[i] = 1'b1;
                    if (start) begin m_ph[i] = 1; m_cnt[i] = 0; end
                end else if (m_ph[i] == 1) begin
                    if (in_valid) begin
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == nr_of(i)) begin
                            m_od[i] = in_data; m_ov[i] = 1'b1; m_ph[i] = 2;
                        end else begin
                            m_fbd[i] = in_data; m_fbv[i] = 1'b1;
                        end
                    end
                end else begin
                    if (in_valid) m_drop[i] = 1'b1;
                    if (out_ready) begin
                        m_ov[i] = 1'b0; m_cnt[i] = 0;
                        m_ph[i] = start ? 1 : 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.fb_valid",  W'(fbv_a),  W'(m_fbv[0]));
            chk("a.fb_data",   fbd_a,      m_fbd[0]);
            chk("a.out_valid", W'(ov_a),   W'(m_ov[0]));
            chk("a.out_data",  od_a,       m_od[0]);
            chk("a.busy",      W'(busy_a), W'(m_ph[0] != 0));
            chk("a.round",     W'(rnd_a),  W'(m_cnt[0]));
            chk("a.drop_err",  W'(drop_a), W'(m_drop[0]));
            chk("b.fb_valid",  W'(fbv_b),  W'(m_fbv[1]));
            chk("b.fb_data",   fbd_b,      m_fbd[1]);
            chk("b.out_valid", W'(ov_b),   W'(m_ov[1]));
            chk("b.out_data",  od_b,       m_od[1]);
            chk("b.busy",      W'(busy_b), W'(m_ph[1] != 0));
            chk("b.round",     W'(rnd_b),  W'(m_cnt[1]));
            chk("b.drop_err",  W'(drop_b), W'(m_drop[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a.fb_valid"},  W'(fbv_a),  '0);
        chk({tag, ".a.fb_data"},   fbd_a,      '0);
        chk({tag, ".a.out_valid"}, W'(ov_a),   '0);
        chk({tag, ".a.out_data"},  od_a,       '0);
        chk({tag, ".a.busy"},      W'(busy_a), '0);
        chk({tag, ".a.round"},     W'(rnd_a),  '0);
        chk({tag, ".a.drop_err"},  W'(drop_a), '0);
        chk({tag, ".b.busy"},      W'(busy_b), '0);
        chk({tag, ".b.out_valid"}, W'(ov_b),   '0);
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [W-1:0] last_d;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Block 1: beats carry their round index.
        start = 1'b1; tick(); start = 1'b0;
        chk("t1.busy", W'(busy_a), W'(1));
        chk("t1.round0", W'(rnd_a), W'(0));
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            tick();
            if (k < 10) begin
                chk("t1.fb_valid", W'(fbv_a), W'(1));
                chk("t1.fb_data", fbd_a, W'(k));
            end else begin
                chk("t1.last_no_fb", W'(fbv_a), W'(0));
                chk("t1.out_valid", W'(ov_a), W'(1));
                chk("t1.out_data", od_a, 128'h0A);
                chk("t1.round10", W'(rnd_a), W'(10));
            end
        end
        in_valid = 1'b0;

        // Hold with the consumer stalled. A stray beat in cycle 2 is dropped.
        for (int c = 1; c <= 5; c++) begin
            in_valid = (c == 2); in_data = rnd128();
            tick();
            chk("t2.hold_data", od_a, 128'h0A);
            chk("t2.hold_valid", W'(ov_a), W'(1));
            chk("t2.drop", W'(drop_a), W'(c == 2));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2.accept_valid", W'(ov_a), W'(0));
        chk("t2.accept_busy", W'(busy_a), W'(0));
        chk("t2.accept_round", W'(rnd_a), W'(0));

        // A beat arriving in IDLE is dropped, and the feedback register is untouched.
        in_valid = 1'b1; in_data = 128'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        chk("t4.drop", W'(drop_a), W'(1));
        chk("t4.no_fb", W'(fbv_a), W'(0));
        chk("t4.fb_kept", fbd_a, W'(9));

        // Back-to-back blocks: accept and start on the same edge.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = rnd128(); tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("t3.busy", W'(busy_a), W'(1));
        chk("t3.round0", W'(rnd_a), W'(0));
        chk("t3.out_dropped", W'(ov_a), W'(0));
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = rnd128(); last_d = in_data; tick();
        end
        in_valid = 1'b0;
        chk("t3.out_valid", W'(ov_a), W'(1));
        chk("t3.out_data", od_a, last_d);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset asserted mid-block, after beat 5.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_data = rnd128(); tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        tick();
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = rnd128(); last_d = in_data; tick();
        end
        in_valid = 1'b0;
        chk("t5.out_valid", W'(ov_a), W'(1));
        chk("t5.out_data", od_a, last_d);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Two-round instance. start during ROUND must not reset the counter.
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 128'h11; tick(); in_valid = 1'b0;
        chk("t6.fb_valid", W'(fbv_b), W'(1));
        chk("t6.fb_data", fbd_b, 128'h11);
        chk("t6.round1", W'(rnd_b), W'(1));
        start = 1'b1; tick(); start = 1'b0;
        chk("t6.start_ignored", W'(rnd_b), W'(1));
        chk("t6.start_ignored_a", W'(rnd_a), W'(1));
        in_valid = 1'b1; in_data = 128'h22; tick(); in_valid = 1'b0;
        chk("t6.no_fb", W'(fbv_b), W'(0));
        chk("t6.out_valid", W'(ov_b), W'(1));
        chk("t6.out_data", od_b, 128'h22);
        chk("t6.round2", W'(rnd_b), W'(2));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 1) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            in_data   = rnd128();
            tick();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
